// File: rtl/ps2_keystroke_decoder.sv
// rtl/ps2_keystroke_decoder.sv - PS/2 frame receiver with E0/F0 tracking and game-key mapping
`timescale 1ns/1ps
module ps2_keystroke_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [4:0] KEYSTROKE,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_VALID,
  output logic       FRAME_ERR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] NO_KEY = 5'h1F;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [4:0]    key_q, key_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  logic          frame_err_q, frame_err_d;

  logic          falling;
  logic [10:0]   frame;
  logic          frame_ok;
  logic [4:0]    code;

  // Returns NO_KEY for bytes that are unmapped under the current ext flag.
  function automatic logic [4:0] map_key(input logic ext, input logic [7:0] b);
    map_key = NO_KEY;
    if (!ext) begin
      case (b)
        8'h1D: map_key = 5'd0;
        8'h1B: map_key = 5'd1;
        8'h1C: map_key = 5'd2;
        8'h23: map_key = 5'd3;
        8'h29: map_key = 5'd8;
        8'h5A: map_key = 5'd9;
        8'h76: map_key = 5'd10;
        default: map_key = NO_KEY;
      endcase
    end else begin
      case (b)
        8'h75: map_key = 5'd4;
        8'h72: map_key = 5'd5;
        8'h6B: map_key = 5'd6;
        8'h74: map_key = 5'd7;
        default: map_key = NO_KEY;
      endcase
    end
  endfunction

  assign falling  = clk_prev_q & ~clk_sync_q[1];
  assign frame    = {dat_sync_q[1], shift_q};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  assign code     = map_key(ext_q, frame[8:1]);

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    key_d        = key_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (falling) begin
      to_cnt_d = '0;
      shift_d  = {dat_sync_q[1], shift_q[9:1]};
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          scan_code_d  = frame[8:1];
          scan_valid_d = 1'b1;
          if (frame[8:1] == 8'hE0) begin
            ext_d = 1'b1;
          end else if (frame[8:1] == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (code != NO_KEY) begin
              if (!brk_q) begin
                key_d = code;
              end else if (key_q == code) begin
                key_d = NO_KEY;
              end
            end
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      // A stalled partial frame is dropped silently so the next start bit realigns.
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_q        <= NO_KEY;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q   <= {dat_sync_q[0], PS2_DATA};
      clk_prev_q   <= clk_sync_q[1];
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_q        <= key_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign KEYSTROKE  = key_q;
  assign SCAN_CODE  = scan_code_q;
  assign SCAN_VALID = scan_valid_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_ps2_keystroke_decoder.sv
// tb/tb_ps2_keystroke_decoder.sv - bench for ps2_keystroke_decoder against a key-state model
`timescale 1ns/1ps
module tb_ps2_keystroke_decoder;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] keystroke;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  int total = 0;
  int bad = 0;
  int sv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int half = 10;

  logic       m_ext, m_brk;
  logic [4:0] m_key;
  logic [7:0] m_code;

  ps2_keystroke_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_dat),
    .KEYSTROKE(keystroke), .SCAN_CODE(scan_code), .SCAN_VALID(scan_valid),
    .FRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) sv_cnt++;
    if (frame_err) fe_cnt++;
    if (scan_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Key code table from the scan code set 2 game map; -1 means not a game key.
  function automatic int key_of(input logic ext, input logic [7:0] b);
    int t0 [8] = '{'h1D, 'h1B, 'h1C, 'h23, 'h29, 'h5A, 'h76, -1};
    int c0 [8] = '{0, 1, 2, 3, 8, 9, 10, -1};
    int t1 [4] = '{'h75, 'h72, 'h6B, 'h74};
    key_of = -1;
    if (!ext) begin
      for (int i = 0; i < 7; i++) if (t0[i] == int'(b)) key_of = c0[i];
    end else begin
      for (int i = 0; i < 4; i++) if (t1[i] == int'(b)) key_of = 4 + i;
    end
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_key = 5'h1F; m_code = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    m_code = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = key_of(m_ext, b);
      if (k >= 0) begin
        if (!m_brk) m_key = 5'(k);
        else if (int'(m_key) == k) m_key = 5'h1F;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] bits;
    bits[0] = 1'b0;
    bits[8:1] = b;
    bits[9] = (~^b) ^ bad_par;
    bits[10] = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_dat = bits[i];
      repeat (half) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (half) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    @(posedge clk); #1 ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int sv0, fe0;
    bit err;
    sv0 = sv_cnt; fe0 = fe_cnt;
    err = bad_par || bad_stop;
    send_bits(b, bad_par, bad_stop, 11);
    if (!err) model_byte(b);
    check({tag, ".valid"}, sv_cnt - sv0, err ? 0 : 1);
    check({tag, ".err"}, fe_cnt - fe0, err ? 1 : 0);
    check({tag, ".code"}, scan_code, m_code);
    check({tag, ".key"}, keystroke, m_key);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int sv0, fe0;
    logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                              8'h5A, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] b;
    bit ep, es;

    do_reset();
    check("rst.key", keystroke, 5'h1F);
    check("rst.code", scan_code, 8'h00);
    check("rst.valid", scan_valid, 1'b0);
    check("rst.err", frame_err, 1'b0);

    do_frame("t1.1D", 8'h1D, 0, 0);
    check("t1.key0", keystroke, 5'd0);

    sv0 = sv_cnt;
    do_frame("t2.E0", 8'hE0, 0, 0);
    do_frame("t2.75", 8'h75, 0, 0);
    check("t2.key4", keystroke, 5'd4);
    do_frame("t2.E0b", 8'hE0, 0, 0);
    do_frame("t2.F0", 8'hF0, 0, 0);
    do_frame("t2.75b", 8'h75, 0, 0);
    check("t2.key1F", keystroke, 5'h1F);
    check("t2.pulses", sv_cnt - sv0, 5);

    do_frame("t3.par", 8'h1D, 1, 0);
    do_frame("t3.stop", 8'h1D, 0, 1);

    do_frame("t4.23", 8'h23, 0, 0);
    do_frame("t4.E0", 8'hE0, 0, 0);
    do_frame("t4.6B", 8'h6B, 0, 0);
    do_frame("t4.F0", 8'hF0, 0, 0);
    do_frame("t4.23b", 8'h23, 0, 0);
    check("t4.key6", keystroke, 5'd6);

    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(8'h1B, 0, 0, 5);
    repeat (TO + 50) @(posedge clk);
    #1;
    check("t5.partial_err", fe_cnt - fe0, 0);
    check("t5.partial_valid", sv_cnt - sv0, 0);
    do_frame("t5.1B", 8'h1B, 0, 0);
    check("t5.key1", keystroke, 5'd1);

    send_bits(8'h29, 0, 0, 7);
    do_reset();
    do_frame("t6.75", 8'h75, 0, 0);
    check("t6.key", keystroke, 5'h1F);
    check("t6.code", scan_code, 8'h75);

    for (int n = 0; n < 40; n++) begin
      half = $urandom_range(4, 12);
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 12)];
      ep = 0; es = 0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) ep = 1; else es = 1;
      end
      do_frame($sformatf("rnd%0d", n), b, ep, es);
    end

    check("never_both", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
